// File: rtl/rf_ctrl_pkg.sv
// Shared widths and FSM state encoding for the register-file access controller.
package rf_ctrl_pkg;

  localparam int DW = 8;
  localparam int AW = 4;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_ISSUE   = 3'd1,
    RD_CAPT    = 3'd2,
    WR_LOAD    = 3'd3,
    WR_STORE   = 3'd4,
    WR_RESTORE = 3'd5,
    ACK        = 3'd6
  } state_t;

endpackage

// File: rtl/rf_access_ctrl.sv
// Arbitrates register-file access between the core and a debug port; a debug write
// borrows ACC as the write path and restores the core's ACC value afterwards.
module rf_access_ctrl #(
  parameter int DW = rf_ctrl_pkg::DW,
  parameter int AW = rf_ctrl_pkg::AW
) (
  input  logic          CLK,
  input  logic          RST_n,
  // core side
  input  logic [AW-1:0] CoreReadAddr,
  input  logic          CoreReadRegEn,
  input  logic [AW-1:0] CoreRegWriteAddr,
  input  logic          CoreWriteRegEn,
  input  logic          CoreWriteACCEn,
  input  logic [DW-1:0] CoreACCWrite,
  output logic          CoreStall,
  // debug side
  input  logic          DbgReq,
  input  logic          DbgWe,
  input  logic [AW-1:0] DbgAddr,
  input  logic [DW-1:0] DbgWData,
  output logic          DbgAck,
  output logic [DW-1:0] DbgRData,
  // register-file side
  output logic [AW-1:0] RfReadAddr,
  output logic [AW-1:0] RfRegWriteAddr,
  output logic          RfReadRegEn,
  output logic          RfWriteRegEn,
  output logic          RfWriteACCEn,
  output logic [DW-1:0] RfACCWrite,
  input  logic [DW-1:0] RfACCRead,
  input  logic [DW-1:0] RfReadDataOut,
  // FSM state observation
  output logic [2:0]    o_dbg_state
);

  import rf_ctrl_pkg::*;

  // Handshake: DbgReq is a level held by the requester until DbgAck; DbgAck is a
  // one-cycle pulse in ACK; CoreStall tells the core to hold its request unchanged.

  state_t        r_state;
  state_t        w_next_state;
  logic          r_core_turn;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_save_acc;
  logic [DW-1:0] r_rdata;
  logic          w_accept;

  // Gated by RST_n so a pending DbgReq cannot stall the core while in reset.
  assign w_accept    = RST_n && (r_state == IDLE) && DbgReq && !r_core_turn;
  assign CoreStall   = RST_n && ((r_state != IDLE) || w_accept);
  assign DbgRData    = r_rdata;
  assign o_dbg_state = r_state;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state     <= IDLE;
      r_core_turn <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_save_acc  <= '0;
      r_rdata     <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_we       <= DbgWe;
        r_addr     <= DbgAddr;
        r_wdata    <= DbgWData;
        r_save_acc <= RfACCRead;
      end
      if (r_state == RD_CAPT) begin
        r_rdata <= RfReadDataOut;
      end
      if (r_state == ACK) begin
        r_core_turn <= 1'b1;
      end else if (r_state == IDLE) begin
        r_core_turn <= 1'b0;
      end
    end
  end

  always_comb begin
    w_next_state   = r_state;
    RfReadAddr     = r_addr;
    RfRegWriteAddr = r_addr;
    RfReadRegEn    = 1'b0;
    RfWriteRegEn   = 1'b0;
    RfWriteACCEn   = 1'b0;
    RfACCWrite     = r_wdata;
    DbgAck         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = DbgWe ? WR_LOAD : RD_ISSUE;
        end else begin
          RfReadAddr     = CoreReadAddr;
          RfRegWriteAddr = CoreRegWriteAddr;
          RfReadRegEn    = CoreReadRegEn;
          RfWriteRegEn   = CoreWriteRegEn;
          RfWriteACCEn   = CoreWriteACCEn;
          RfACCWrite     = CoreACCWrite;
        end
      end
      RD_ISSUE: begin
        RfReadRegEn  = 1'b1;
        w_next_state = RD_CAPT;
      end
      RD_CAPT: begin
        w_next_state = ACK;
      end
      WR_LOAD: begin
        RfWriteACCEn = 1'b1;
        w_next_state = WR_STORE;
      end
      WR_STORE: begin
        RfWriteRegEn = 1'b1;
        w_next_state = WR_RESTORE;
      end
      WR_RESTORE: begin
        // Put back the ACC value the core owned at accept time.
        RfWriteACCEn = 1'b1;
        RfACCWrite   = r_save_acc;
        w_next_state = ACK;
      end
      ACK: begin
        DbgAck       = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Directed plus randomized bench for rf_access_ctrl with a small register-file
// environment and a transaction-level model of register/ACC contents.
module tb_rf_access_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;

  // clock / reset
  logic CLK = 1'b0;
  logic RST_n = 1'b0;
  always #5 CLK = ~CLK;

  logic [AW-1:0] CoreReadAddr, CoreRegWriteAddr, DbgAddr;
  logic          CoreReadRegEn, CoreWriteRegEn, CoreWriteACCEn;
  logic [DW-1:0] CoreACCWrite, DbgWData;
  logic          DbgReq, DbgWe;
  logic          CoreStall, DbgAck;
  logic [DW-1:0] DbgRData;
  logic [AW-1:0] RfReadAddr, RfRegWriteAddr;
  logic          RfReadRegEn, RfWriteRegEn, RfWriteACCEn;
  logic [DW-1:0] RfACCWrite, RfACCRead, RfReadDataOut;
  logic [2:0]    o_dbg_state;

  rf_access_ctrl #(.DW(DW), .AW(AW)) dut (
    .CLK(CLK), .RST_n(RST_n),
    .CoreReadAddr(CoreReadAddr), .CoreReadRegEn(CoreReadRegEn),
    .CoreRegWriteAddr(CoreRegWriteAddr), .CoreWriteRegEn(CoreWriteRegEn),
    .CoreWriteACCEn(CoreWriteACCEn), .CoreACCWrite(CoreACCWrite),
    .CoreStall(CoreStall),
    .DbgReq(DbgReq), .DbgWe(DbgWe), .DbgAddr(DbgAddr), .DbgWData(DbgWData),
    .DbgAck(DbgAck), .DbgRData(DbgRData),
    .RfReadAddr(RfReadAddr), .RfRegWriteAddr(RfRegWriteAddr),
    .RfReadRegEn(RfReadRegEn), .RfWriteRegEn(RfWriteRegEn),
    .RfWriteACCEn(RfWriteACCEn), .RfACCWrite(RfACCWrite),
    .RfACCRead(RfACCRead), .RfReadDataOut(RfReadDataOut),
    .o_dbg_state(o_dbg_state)
  );

  // register-file environment (no reset, synchronous read)
  logic [DW-1:0] rf_regs [16];
  logic [DW-1:0] rf_acc;
  logic [DW-1:0] rf_rdata;
  always @(posedge CLK) begin
    if (RfWriteACCEn) rf_acc <= RfACCWrite;
    if (RfWriteRegEn) rf_regs[RfRegWriteAddr] <= rf_acc;
    if (RfReadRegEn)  rf_rdata <= rf_regs[RfReadAddr];
  end
  assign RfACCRead     = rf_acc;
  assign RfReadDataOut = rf_rdata;

  // reference model
  logic [DW-1:0] m_regs [16];
  logic [DW-1:0] m_acc;
  logic [DW-1:0] m_rdata;
  bit            m_turn;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: one unstalled core cycle
  task automatic core_cycle(input logic en_acc, input logic [DW-1:0] acc_d,
                            input logic en_reg, input logic [AW-1:0] reg_a,
                            input logic en_rd, input logic [AW-1:0] rd_a);
    DbgReq = 1'b0;
    CoreWriteACCEn = en_acc; CoreACCWrite = acc_d;
    CoreWriteRegEn = en_reg; CoreRegWriteAddr = reg_a;
    CoreReadRegEn = en_rd;   CoreReadAddr = rd_a;
    @(negedge CLK);
    chk("core_stall", CoreStall, 0);
    chk("core_ack", DbgAck, 0);
    chk("pt_acc_en", RfWriteACCEn, en_acc);
    chk("pt_reg_en", RfWriteRegEn, en_reg);
    chk("pt_rd_en", RfReadRegEn, en_rd);
    if (en_acc) chk("pt_acc_d", RfACCWrite, acc_d);
    if (en_reg) chk("pt_wr_a", RfRegWriteAddr, reg_a);
    if (en_rd)  chk("pt_rd_a", RfReadAddr, rd_a);
    chk("rdata_hold", DbgRData, m_rdata);
    @(posedge CLK); #1;
    if (en_reg) m_regs[reg_a] = m_acc;
    if (en_acc) m_acc = acc_d;
    m_turn = 1'b0;
  endtask

  task automatic core_read_check(input logic [AW-1:0] a);
    logic [DW-1:0] exp_d;
    exp_d = m_regs[a];
    core_cycle(1'b0, '0, 1'b0, '0, 1'b1, a);
    chk("core_rd_data", RfReadDataOut, exp_d);
  endtask

  // driver: full debug operation, sampled every cycle against expected timing
  task automatic dbg_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input bit drop_ok);
    int t, lat;
    logic [DW-1:0] exp_rd;
    t = m_turn ? 1 : 0;
    lat = we ? 4 : 3;
    exp_rd = m_regs[a];
    DbgReq = 1'b1; DbgWe = we; DbgAddr = a; DbgWData = wd;
    for (int i = 0; i <= t + lat; i++) begin
      if (t == 1 && i == 0) begin
        CoreReadRegEn = 1'b1; CoreReadAddr = AW'($urandom);
        CoreWriteRegEn = 1'b0; CoreWriteACCEn = 1'b0;
      end else begin
        CoreReadRegEn = 1'($urandom); CoreReadAddr = AW'($urandom);
        CoreWriteRegEn = 1'($urandom); CoreRegWriteAddr = AW'($urandom);
        CoreWriteACCEn = 1'($urandom); CoreACCWrite = DW'($urandom);
      end
      @(negedge CLK);
      if (t == 1 && i == 0) begin
        chk("turn_stall", CoreStall, 0);
        chk("turn_rd_en", RfReadRegEn, 1);
        chk("turn_acc_en", RfWriteACCEn, 0);
      end else begin
        chk("op_stall", CoreStall, 1);
        chk("op_rd_en", RfReadRegEn, !we && i == t + 1);
        chk("op_reg_en", RfWriteRegEn, we && i == t + 2);
        chk("op_acc_en", RfWriteACCEn, we && (i == t + 1 || i == t + 3));
        if (!we && i == t + 1) chk("op_rd_a", RfReadAddr, a);
        if (we && i == t + 2) chk("op_wr_a", RfRegWriteAddr, a);
        if (we && i == t + 1) chk("op_load_d", RfACCWrite, wd);
        if (we && i == t + 3) chk("op_restore_d", RfACCWrite, m_acc);
      end
      chk("op_ack", DbgAck, i == t + lat);
      if (i == t + lat && !we) chk("op_rdata", DbgRData, exp_rd);
      @(posedge CLK); #1;
      if (drop_ok && i > t && i < t + lat && $urandom_range(0, 3) == 0) DbgReq = 1'b0;
    end
    if (we) m_regs[a] = wd;
    else    m_rdata = exp_rd;
    m_turn = 1'b1;
    chk("acc_kept", RfACCRead, m_acc);
  endtask

  initial begin
    logic [DW-1:0] v;
    logic [AW-1:0] a;
    int kind;
    m_acc = '0; m_rdata = '0; m_turn = 1'b0;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    DbgReq = 1'b1; DbgWe = 1'b0; DbgAddr = '0; DbgWData = '0;
    CoreReadAddr = 4'h3; CoreReadRegEn = 1'b1; CoreRegWriteAddr = 4'h5;
    CoreWriteRegEn = 1'b0; CoreWriteACCEn = 1'b1; CoreACCWrite = 8'hA5;

    // reset: outputs idle, pass-through active, no stall even with DbgReq high
    #3;
    chk("rst_stall", CoreStall, 0);
    chk("rst_ack", DbgAck, 0);
    chk("rst_rdata", DbgRData, 0);
    chk("rst_state", o_dbg_state, 0);
    chk("rst_pt_rd_a", RfReadAddr, 4'h3);
    chk("rst_pt_acc", RfACCWrite, 8'hA5);
    @(negedge CLK);
    CoreReadAddr = 4'hC; CoreRegWriteAddr = 4'hE; CoreWriteRegEn = 1'b1; CoreACCWrite = 8'h3C;
    #1;
    chk("rst_pt_rd_a2", RfReadAddr, 4'hC);
    chk("rst_pt_wr_a2", RfRegWriteAddr, 4'hE);
    chk("rst_pt_reg_en", RfWriteRegEn, 1);
    chk("rst_pt_acc2", RfACCWrite, 8'h3C);
    @(posedge CLK); #1;
    RST_n = 1'b1; DbgReq = 1'b0;

    // pass-through: ACC <- 07, reg1 <- ACC, read reg1
    core_cycle(1'b1, 8'h07, 1'b0, '0, 1'b0, '0);
    core_cycle(1'b0, '0, 1'b1, 4'h1, 1'b0, '0);
    core_read_check(4'h1);

    // give every register a known value
    for (int i = 0; i < 16; i++) begin
      core_cycle(1'b1, DW'($urandom), 1'b0, '0, 1'b0, '0);
      core_cycle(1'b0, '0, 1'b1, AW'(i), 1'b0, '0);
    end

    // debug read of reg9 = 5A
    core_cycle(1'b1, 8'h5A, 1'b0, '0, 1'b0, '0);
    core_cycle(1'b0, '0, 1'b1, 4'h9, 1'b0, '0);
    dbg_op(1'b0, 4'h9, '0, 1'b0);
    chk("dbg_rd_5a", DbgRData, 8'h5A);

    // debug write C4 to reg2 with ACC=33
    core_cycle(1'b1, 8'h33, 1'b0, '0, 1'b0, '0);
    dbg_op(1'b1, 4'h2, 8'hC4, 1'b1);
    chk("dbg_wr_acc33", RfACCRead, 8'h33);
    core_read_check(4'h2);

    // two back-to-back debug writes: exactly one unstalled core cycle between
    dbg_op(1'b1, 4'h6, 8'h91, 1'b0);
    dbg_op(1'b1, 4'h7, 8'h1E, 1'b0);
    core_read_check(4'h6);
    core_read_check(4'h7);

    // reset while in WR_STORE
    core_cycle(1'b1, 8'h44, 1'b0, '0, 1'b0, '0);
    DbgReq = 1'b1; DbgWe = 1'b1; DbgAddr = 4'hB; DbgWData = 8'hEE;
    CoreWriteACCEn = 1'b0; CoreWriteRegEn = 1'b0; CoreReadRegEn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) begin @(posedge CLK); #1; end
    end
    #2;
    RST_n = 1'b0;
    #1;
    chk("rst_mid_state", o_dbg_state, 0);
    chk("rst_mid_ack", DbgAck, 0);
    chk("rst_mid_stall", CoreStall, 0);
    chk("rst_mid_reg_en", RfWriteRegEn, 0);
    @(posedge CLK); #1;
    RST_n = 1'b1; DbgReq = 1'b0;
    m_rdata = '0; m_turn = 1'b0;
    core_cycle(1'b1, 8'h21, 1'b0, '0, 1'b0, '0);
    core_read_check(4'hB);

    // randomized mix
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 3);
      a = AW'($urandom);
      v = DW'($urandom);
      case (kind)
        0: dbg_op(1'b0, a, '0, 1'b1);
        1: dbg_op(1'b1, a, v, 1'b1);
        2: core_cycle(1'($urandom), v, 1'($urandom), a, 1'($urandom), AW'($urandom));
        default: core_read_check(a);
      endcase
    end
    core_cycle(1'b0, '0, 1'b0, '0, 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
